pcs_tx_sym_gen: RTL

//  100BASE-T1 PCS transmit symbol generator plus local-receiver lock tracker; the DUT stage driven by the con UVC.

---
 rtl/pcs_tx_sym_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pcs_tx_sym_gen.sv
// 100BASE-T1 PCS transmit symbol generator: side-stream scrambler, 3B2T mapper,
// tx-mode state register and rcv_vld lock/unlock tracker.
module pcs_tx_sym_gen #(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic        clk_33m,
   input  logic        rstn,
   input  logic [32:0] seed,
   input  logic [1:0]  tx_mode,
   input  logic        master_slave,
   input  logic        rcv_vld,
   input  logic [2:0]  tx_data,
   output logic        tx_enable,
   output logic        loc_rcvr_status,
   output logic [1:0]  TAn,
   output logic [1:0]  TBn
);

   localparam int OKW  = $clog2(LOCK_CNT + 1);
   localparam int BADW = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {
      ST_ZERO = 2'd0,
      ST_IDLE = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t          r_state;
   logic [32:0]     r_scr;
   logic [1:0]      r_ta;
   logic [1:0]      r_tb;
   logic            r_status;
   logic [OKW-1:0]  r_ok_cnt;
   logic [BADW-1:0] r_bad_cnt;

   state_t      w_mode;
   logic [2:0]  w_s;
   logic [2:0]  w_sd;
   logic        w_fb;
   logic [1:0]  w_ta;
   logic [1:0]  w_tb;
   logic        w_lock_hit;
   logic        w_unlock_hit;

   // Reserved mode 3 behaves exactly like SEND_Z.
   always_comb begin
      w_mode = ST_ZERO;
      case (tx_mode)
         2'd1:    w_mode = ST_IDLE;
         2'd2:    w_mode = ST_DATA;
         default: w_mode = ST_ZERO;
      endcase
   end

   assign w_s  = {r_scr[6] ^ r_scr[16], r_scr[3] ^ r_scr[8], r_scr[0]};
   assign w_sd = (w_mode == ST_DATA) ? (tx_data ^ w_s) : w_s;
   assign w_fb = r_scr[32] ^ (master_slave ? r_scr[12] : r_scr[19]);

   // 3B2T: -1 -> 2'b11, 0 -> 2'b00, +1 -> 2'b01
   always_comb begin
      w_ta = 2'b00;
      w_tb = 2'b00;
      case (w_sd)
         3'b000: begin w_ta = 2'b11; w_tb = 2'b11; end
         3'b001: begin w_ta = 2'b11; w_tb = 2'b00; end
         3'b010: begin w_ta = 2'b11; w_tb = 2'b01; end
         3'b011: begin w_ta = 2'b00; w_tb = 2'b11; end
         3'b100: begin w_ta = 2'b00; w_tb = 2'b01; end
         3'b101: begin w_ta = 2'b01; w_tb = 2'b11; end
         3'b110: begin w_ta = 2'b01; w_tb = 2'b00; end
         default: begin w_ta = 2'b01; w_tb = 2'b01; end
      endcase
   end

   assign w_lock_hit   = rcv_vld  && (r_ok_cnt  == OKW'(LOCK_CNT - 1));
   assign w_unlock_hit = !rcv_vld && (r_bad_cnt == BADW'(UNLOCK_CNT - 1));

   always_ff @(posedge clk_33m) begin
      if (!rstn) begin
         r_state   <= ST_ZERO;
         r_scr     <= 33'h1;
         r_ta      <= 2'b00;
         r_tb      <= 2'b00;
         r_status  <= 1'b0;
         r_ok_cnt  <= '0;
         r_bad_cnt <= '0;
      end else begin
         r_state <= w_mode;

         // An all-zero scrambler would lock up, so a zero seed loads 1.
         if (w_mode == ST_ZERO) begin
            r_scr <= (seed == 33'd0) ? 33'h1 : seed;
            r_ta  <= 2'b00;
            r_tb  <= 2'b00;
         end else begin
            r_scr <= {r_scr[31:0], w_fb};
            r_ta  <= w_ta;
            r_tb  <= w_tb;
         end

         if (rcv_vld) begin
            r_bad_cnt <= '0;
            if (r_ok_cnt != OKW'(LOCK_CNT))
               r_ok_cnt <= r_ok_cnt + OKW'(1);
         end else begin
            r_ok_cnt <= '0;
            if (r_bad_cnt != BADW'(UNLOCK_CNT))
               r_bad_cnt <= r_bad_cnt + BADW'(1);
         end

         if (w_lock_hit)
            r_status <= 1'b1;
         else if (w_unlock_hit)
            r_status <= 1'b0;
      end
   end

   assign tx_enable       = (r_state == ST_DATA);
   assign loc_rcvr_status = r_status;
   assign TAn             = r_ta;
   assign TBn             = r_tb;

endmodule
